execute_stage_pipe: RTL and testbench
=====================================

EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal values 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): width of the shift-amount field.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port in_valid  input  1  operation presented this cycle.
REQ-006 Port busy  output  1  multi-cycle op in flight; upstream holds its inputs while high.
REQ-007 Port flush  input  1  synchronous cancel of the in-flight or presented op.
REQ-008 Port op1, op2, inport, immediate  input  WIDTH each  register operands, input-port value, sign-extended immediate.
REQ-009 Port shamt  input  SHW  shift amount.
REQ-010 Port alu_op  input  5  operation code, from the package encoding.
REQ-011 Port alu_src  input  2  op2 source: 0 forwarded op2, 1 immediate, 2 zero-extended shamt.
REQ-012 Port in_sel  input  1  op1 base: 0 op1, 1 inport.
REQ-013 Port fwd1_sel, fwd2_sel  input  2 each  0 base, 1 fwd_exmem, 2 fwd_memwb; 3 treated as 0.
REQ-014 Port fwd_exmem, fwd_memwb  input  WIDTH each  forwarded results.
REQ-015 Port out_valid  output  1  one-cycle pulse per completed op.
REQ-016 Port result, result_hi  output  WIDTH each  result; result_hi is the upper half of a MUL product, else 0.
REQ-017 Port mem_addr  output  WIDTH  registered final op2, captured with result.
REQ-018 Port ccr  output  3  flag register: bit0 Z, bit1 N, bit2 C.

Function
REQ-019 Operand A is in_sel-selected base, then fwd1_sel-selected; operand B is fwd2_sel-selected op2, then alu_src-selected; selection is combinational.
REQ-020 Ops: NOP, MOV(A), ADD, SUB(A-B), AND, OR, NOT(A), INC(A), DEC(A), SHL(A<<B), SHR(A>>B logical), SETC, CLRC, MUL (unsigned, 2*WIDTH product); undefined codes behave as NOP.
REQ-021 A single-cycle op is accepted at edge E when in_valid=1, busy=0, flush=0; result, mem_addr, ccr and out_valid=1 register at E, giving 1-cycle latency.
REQ-022 out_valid is 0 in any cycle following an edge with no completion.
REQ-023 States: IDLE and MUL; MUL accepted at E0 enters MUL, busy=1, and shift-add iterates exactly WIDTH edges; at edge E0+WIDTH it returns to IDLE with out_valid=1.
REQ-024 MUL operands are latched at acceptance; input changes while busy have no effect, and in_valid while busy is ignored.
REQ-025 ADD/INC: C = carry-out; SUB/DEC: C = borrow.
REQ-026 SHL: C = last bit shifted out; SHR: C = last bit shifted out; shamt=0 leaves C unchanged and result=A.
REQ-027 SETC sets C=1 and CLRC sets C=0, with Z/N unchanged; NOP and undefined codes leave ccr unchanged and pulse out_valid.
REQ-028 Z and N are updated from result for ADD..SHR; for MUL, Z and N come from the full 2*WIDTH product, and C is unchanged.
REQ-029 All arithmetic is modulo 2^WIDTH; wrap is silent apart from C.
REQ-030 A flush while busy returns to IDLE at that edge, with no out_valid and ccr unchanged; a flush with in_valid in IDLE drops the op.
REQ-031 A MUL accepted in the same cycle as its completion edge cannot occur, because busy blocks acceptance; the next op may be accepted at the edge after busy falls.

Reset
REQ-032 While rst_n=0: state=IDLE, busy=0, out_valid=0, result=0, result_hi=0, mem_addr=0, ccr=3'b000.
REQ-033 Reset asserted mid-MUL aborts it immediately, with no completion pulse after release.
REQ-034 The first op may be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-035 Package exec_pkg holds the alu_op encodings, the IDLE/MUL state type, the flag bit indices Z/N/C, and the fwd/alu_src select constants.
REQ-036 The iterative multiplier is the sub-module seq_multiplier (start, done, WIDTH-parametrised); all other logic is in execute_stage_pipe.

Verification
REQ-037 WIDTH=16: ADD A=0xFFFF, B=0x0001 -> next cycle result=0x0000, ccr Z=1 N=0 C=1, out_valid pulse.
REQ-038 MUL A=0x1234, B=0x0100 -> busy high 16 cycles, then result=0x3400, result_hi=0x0012, Z=0, N=0.
REQ-039 fwd1_sel=1 (fwd_exmem=0x0005), fwd2_sel=2 (fwd_memwb=0x0003), SUB -> result=0x0002, C=0.
REQ-040 SHL A=0x8001, shamt=1, alu_src=2 -> result=0x0002, C=1; then SHR with shamt=0 -> result=A, C stays 1.
REQ-041 MUL started, flush at cycle 5 -> busy=0 next cycle, no out_valid, ccr unchanged; a following ADD completes normally.
REQ-042 rst_n pulled low at cycle 8 of a MUL -> all outputs 0 immediately; no out_valid after release.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared encodings for the execute stage: ALU operation codes,
//               FSM state type, CCR flag bit positions and operand-select
//               constants.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  // ALU operation codes (5-bit). Codes not listed here behave as NOP.
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_MOV  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_INC  = 5'd7;
  localparam logic [4:0] OP_DEC  = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_SHR  = 5'd10;
  localparam logic [4:0] OP_SETC = 5'd11;
  localparam logic [4:0] OP_CLRC = 5'd12;
  localparam logic [4:0] OP_MUL  = 5'd13;

  // Execute-stage control states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Bit positions inside the 3-bit condition-code register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // Forwarding select values (3 falls back to the base operand).
  localparam logic [1:0] FWD_BASE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Operand-B source select values (3 falls back to forwarded op2).
  localparam logic [1:0] SRC_OP2   = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/execute_stage_pipe_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Unsigned shift-add multiplier, one partial product per clock.
//               The first step is folded into the start edge, so done is
//               high in the cycle after WIDTH-1 further edges and the
//               consumer can register the product on the WIDTH-th edge.
// Ports       : clk, rst_n   - clock, async active-low reset
//               start        - latch a/b and begin (ignored during abort)
//               abort        - cancel the operation in flight
//               a, b         - multiplicand / multiplier
//               done         - product valid this cycle (combinational)
//               product      - 2*WIDTH bit unsigned product
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // Right-shifting accumulator: upper half collects partial sums, lower half
  // holds the not-yet-consumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  assign done    = run_q && (cnt_q == CW'(WIDTH));
  assign product = p_q;

  always_comb begin
    p_d   = p_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      p_d   = mul_step({{WIDTH{1'b0}}, b}, a);
      m_d   = a;
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (done) begin
        run_d = 1'b0;
      end else begin
        p_d   = mul_step(p_q, m_q);
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pipe
// Description : Pipeline execute stage. Operand forwarding/selection, a
//               single-cycle ALU with Z/N/C flags, and an iterative MUL that
//               stalls upstream via busy for WIDTH cycles.
// Ports       : clk, rst_n                - clock, async active-low reset
//               in_valid, flush, busy     - op handshake / cancel / stall
//               op1, op2, inport, immediate, shamt - operand sources
//               alu_op, alu_src, in_sel, fwd1_sel, fwd2_sel - controls
//               fwd_exmem, fwd_memwb      - forwarded results
//               out_valid, result, result_hi, mem_addr, ccr - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             busy,
  input  logic             flush,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] inport,
  input  logic [WIDTH-1:0] immediate,
  input  logic [SHW-1:0]   shamt,
  input  logic [4:0]       alu_op,
  input  logic [1:0]       alu_src,
  input  logic             in_sel,
  input  logic [1:0]       fwd1_sel,
  input  logic [1:0]       fwd2_sel,
  input  logic [WIDTH-1:0] fwd_exmem,
  input  logic [WIDTH-1:0] fwd_memwb,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] mem_addr,
  output logic [2:0]       ccr
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [2:0]         ccr_q, ccr_d;
  logic [WIDTH-1:0]   b_lat_q, b_lat_d;   // MUL op2, reported at completion

  logic [WIDTH-1:0]   a_base, opa, b_fwd, opb;
  logic [WIDTH-1:0]   alu_res;
  logic [2:0]         alu_ccr;
  logic               upd_zn;
  logic [WIDTH:0]     sum, diff, inc, dec, shl_ext, shr_ext;

  logic               mul_start, mul_abort, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // ---------------- operand selection ----------------
  always_comb begin
    a_base = in_sel ? inport : op1;
    case (fwd1_sel)
      FWD_EXMEM: opa = fwd_exmem;
      FWD_MEMWB: opa = fwd_memwb;
      default:   opa = a_base;
    endcase
    case (fwd2_sel)
      FWD_EXMEM: b_fwd = fwd_exmem;
      FWD_MEMWB: b_fwd = fwd_memwb;
      default:   b_fwd = op2;
    endcase
    case (alu_src)
      SRC_IMM:   opb = immediate;
      SRC_SHAMT: opb = {{(WIDTH-SHW){1'b0}}, shamt};
      default:   opb = b_fwd;
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  // Top bit of each extended value is the carry/borrow/shifted-out bit.
  // Shifting a WIDTH+1 vector lets the last bit out land in a fixed position;
  // amounts beyond WIDTH shift out zeros, which is the correct last bit.
  assign sum     = {1'b0, opa} + {1'b0, opb};
  assign diff    = {1'b0, opa} - {1'b0, opb};
  assign inc     = {1'b0, opa} + {{WIDTH{1'b0}}, 1'b1};
  assign dec     = {1'b0, opa} - {{WIDTH{1'b0}}, 1'b1};
  assign shl_ext = {1'b0, opa} << opb;
  assign shr_ext = {opa, 1'b0} >> opb;

  always_comb begin
    alu_res = '0;          // NOP, SETC, CLRC and undefined codes yield 0
    alu_ccr = ccr_q;
    upd_zn  = 1'b0;
    case (alu_op)
      OP_MOV: alu_res = opa;
      OP_ADD: begin {alu_ccr[FLAG_C], alu_res} = sum;  upd_zn = 1'b1; end
      OP_SUB: begin {alu_ccr[FLAG_C], alu_res} = diff; upd_zn = 1'b1; end
      OP_AND: begin alu_res = opa & opb; upd_zn = 1'b1; end
      OP_OR:  begin alu_res = opa | opb; upd_zn = 1'b1; end
      OP_NOT: begin alu_res = ~opa;      upd_zn = 1'b1; end
      OP_INC: begin {alu_ccr[FLAG_C], alu_res} = inc;  upd_zn = 1'b1; end
      OP_DEC: begin {alu_ccr[FLAG_C], alu_res} = dec;  upd_zn = 1'b1; end
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        if (opb != '0) alu_ccr[FLAG_C] = shl_ext[WIDTH];
        upd_zn = 1'b1;
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        if (opb != '0) alu_ccr[FLAG_C] = shr_ext[0];
        upd_zn = 1'b1;
      end
      OP_SETC: alu_ccr[FLAG_C] = 1'b1;
      OP_CLRC: alu_ccr[FLAG_C] = 1'b0;
      default: ;
    endcase
    if (upd_zn) begin
      alu_ccr[FLAG_Z] = (alu_res == '0);
      alu_ccr[FLAG_N] = alu_res[WIDTH-1];
    end
  end

  // ---------------- control FSM / output registers ----------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    mem_addr_d  = mem_addr_q;
    ccr_d       = ccr_q;
    b_lat_d     = b_lat_q;
    mul_start   = 1'b0;
    mul_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (alu_op == OP_MUL) begin
            mul_start = 1'b1;
            b_lat_d   = opb;
            state_d   = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            mem_addr_d  = opb;
            ccr_d       = alu_ccr;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          mul_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (mul_done) begin
          state_d          = ST_IDLE;
          out_valid_d      = 1'b1;
          result_d         = mul_prod[WIDTH-1:0];
          result_hi_d      = mul_prod[2*WIDTH-1:WIDTH];
          mem_addr_d       = b_lat_q;
          ccr_d[FLAG_Z]    = (mul_prod == '0);
          ccr_d[FLAG_N]    = mul_prod[2*WIDTH-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      mem_addr_q  <= '0;
      ccr_q       <= 3'b000;
      b_lat_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      mem_addr_q  <= mem_addr_d;
      ccr_q       <= ccr_d;
      b_lat_q     <= b_lat_d;
    end
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign busy      = (state_q == ST_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign mem_addr  = mem_addr_q;
  assign ccr       = ccr_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage_pipe
// Description : Directed self-checking bench for execute_stage_pipe, WIDTH=16.
//               ccr is {C,N,Z}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage_pipe;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, in_sel;
  logic [15:0] op1, op2, inport, immediate, fwd_exmem, fwd_memwb;
  logic [3:0]  shamt;
  logic [4:0]  alu_op;
  logic [1:0]  alu_src, fwd1_sel, fwd2_sel;
  logic        busy, out_valid;
  logic [15:0] result, result_hi, mem_addr;
  logic [2:0]  ccr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  execute_stage_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .busy(busy), .flush(flush),
    .op1(op1), .op2(op2), .inport(inport), .immediate(immediate), .shamt(shamt),
    .alu_op(alu_op), .alu_src(alu_src), .in_sel(in_sel),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
    .out_valid(out_valid), .result(result), .result_hi(result_hi),
    .mem_addr(mem_addr), .ccr(ccr)
  );

  // Drive a plain register-operand op; callers tweak selects afterwards.
  task automatic set_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; flush = 1'b0; alu_op = op; op1 = a; op2 = b;
    alu_src = SRC_OP2; in_sel = 1'b0; fwd1_sel = FWD_BASE; fwd2_sel = FWD_BASE;
    shamt = 4'd0; immediate = 16'h0; inport = 16'h0; fwd_exmem = 16'h0; fwd_memwb = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a MUL and wait (bounded) for its completion pulse.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output bit seen, output int busy_cnt);
    @(negedge clk); set_op(OP_MUL, a, b);
    tick();
    busy_cnt = busy ? 1 : 0;
    seen = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_op(OP_NOP, 16'h0, 16'h0); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
    n_tests++; if ({result, result_hi, mem_addr} !== 48'h0) begin n_fail++; $display("FAIL rst_data: got %h/%h/%h exp 0", result, result_hi, mem_addr); end
    n_tests++; if (ccr !== 3'b000) begin n_fail++; $display("FAIL rst_ccr: got %b exp 000", ccr); end
    // First op at the first edge after release: ADD 0xFFFF + 1.
    @(negedge clk); rst_n = 1'b1; set_op(OP_ADD, 16'hFFFF, 16'h0001);
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b exp 1", out_valid); end
    n_tests++; if (result !== 16'h0000) begin n_fail++; $display("FAIL add_wrap_res: got %h exp 0000", result); end
    n_tests++; if (ccr !== 3'b101) begin n_fail++; $display("FAIL add_wrap_ccr: got %b exp 101", ccr); end
    n_tests++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL add_mem_addr: got %h exp 0001", mem_addr); end
    @(negedge clk); in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b exp 0", out_valid); end
  endtask

  task automatic test_add();
    @(negedge clk); set_op(OP_ADD, 16'h7FFF, 16'h0001);
    tick();
    n_tests++; if (result !== 16'h8000 || ccr !== 3'b010) begin n_fail++; $display("FAIL add_n: got %h/%b exp 8000/010", result, ccr); end
    @(negedge clk); set_op(OP_ADD, 16'h1111, 16'h2222);
    in_sel = 1'b1; inport = 16'h0010; alu_src = SRC_IMM; immediate = 16'h0020;
    tick();
    n_tests++; if (result !== 16'h0030 || ccr !== 3'b000) begin n_fail++; $display("FAIL add_inport_imm: got %h/%b exp 0030/000", result, ccr); end
    n_tests++; if (mem_addr !== 16'h0020) begin n_fail++; $display("FAIL imm_mem_addr: got %h exp 0020", mem_addr); end
  endtask

  task automatic test_fwd_sub();
    @(negedge clk); set_op(OP_SUB, 16'h1111, 16'h9999);
    fwd1_sel = FWD_EXMEM; fwd_exmem = 16'h0005; fwd2_sel = FWD_MEMWB; fwd_memwb = 16'h0003;
    tick();
    n_tests++; if (result !== 16'h0002 || ccr !== 3'b000) begin n_fail++; $display("FAIL fwd_sub: got %h/%b exp 0002/000", result, ccr); end
    n_tests++; if (mem_addr !== 16'h0003) begin n_fail++; $display("FAIL fwd_mem_addr: got %h exp 0003", mem_addr); end
  endtask

  task automatic test_shift();
    @(negedge clk); set_op(OP_SHL, 16'h8001, 16'h0); alu_src = SRC_SHAMT; shamt = 4'd1;
    tick();
    n_tests++; if (result !== 16'h0002 || ccr !== 3'b100) begin n_fail++; $display("FAIL shl1: got %h/%b exp 0002/100", result, ccr); end
    @(negedge clk); set_op(OP_SHR, 16'h8001, 16'h0); alu_src = SRC_SHAMT; shamt = 4'd0;
    tick();
    n_tests++; if (result !== 16'h8001 || ccr !== 3'b110) begin n_fail++; $display("FAIL shr0: got %h/%b exp 8001/110", result, ccr); end
    @(negedge clk); set_op(OP_SHR, 16'h00F8, 16'h0); alu_src = SRC_SHAMT; shamt = 4'd4;
    tick();
    n_tests++; if (result !== 16'h000F || ccr !== 3'b100) begin n_fail++; $display("FAIL shr4a: got %h/%b exp 000f/100", result, ccr); end
    @(negedge clk); set_op(OP_SHR, 16'h0008, 16'h0); alu_src = SRC_SHAMT; shamt = 4'd4;
    tick();
    n_tests++; if (result !== 16'h0000 || ccr !== 3'b101) begin n_fail++; $display("FAIL shr4b: got %h/%b exp 0000/101", result, ccr); end
    @(negedge clk); set_op(OP_SHR, 16'h0010, 16'h0); alu_src = SRC_SHAMT; shamt = 4'd4;
    tick();
    n_tests++; if (result !== 16'h0001 || ccr !== 3'b000) begin n_fail++; $display("FAIL shr4c: got %h/%b exp 0001/000", result, ccr); end
  endtask

  task automatic test_flags();
    @(negedge clk); set_op(OP_ADD, 16'h8000, 16'h0000);
    tick();
    n_tests++; if (ccr !== 3'b010) begin n_fail++; $display("FAIL flag_pre: got %b exp 010", ccr); end
    @(negedge clk); set_op(OP_SETC, 16'h0, 16'h0);
    tick();
    n_tests++; if (ccr !== 3'b110 || out_valid !== 1'b1) begin n_fail++; $display("FAIL setc: got %b/%b exp 110/1", ccr, out_valid); end
    @(negedge clk); set_op(OP_NOP, 16'h1234, 16'h5678);
    tick();
    n_tests++; if (ccr !== 3'b110 || out_valid !== 1'b1) begin n_fail++; $display("FAIL nop: got %b/%b exp 110/1", ccr, out_valid); end
    @(negedge clk); set_op(5'h1F, 16'hFFFF, 16'hFFFF);
    tick();
    n_tests++; if (ccr !== 3'b110 || out_valid !== 1'b1) begin n_fail++; $display("FAIL undef_op: got %b/%b exp 110/1", ccr, out_valid); end
    @(negedge clk); set_op(OP_CLRC, 16'h0, 16'h0);
    tick();
    n_tests++; if (ccr !== 3'b010) begin n_fail++; $display("FAIL clrc: got %b exp 010", ccr); end
  endtask

  task automatic test_inc_dec();
    @(negedge clk); set_op(OP_INC, 16'hFFFF, 16'h0);
    tick();
    n_tests++; if (result !== 16'h0000 || ccr !== 3'b101) begin n_fail++; $display("FAIL inc_wrap: got %h/%b exp 0000/101", result, ccr); end
    @(negedge clk); set_op(OP_DEC, 16'h0000, 16'h0);
    tick();
    n_tests++; if (result !== 16'hFFFF || ccr !== 3'b110) begin n_fail++; $display("FAIL dec_borrow: got %h/%b exp ffff/110", result, ccr); end
    @(negedge clk); set_op(OP_AND, 16'hF0F0, 16'h0FF0);
    tick();
    n_tests++; if (result !== 16'h00F0 || ccr !== 3'b100) begin n_fail++; $display("FAIL and: got %h/%b exp 00f0/100", result, ccr); end
  endtask

  task automatic test_mul();
    bit seen;
    int busy_cnt;
    @(negedge clk); set_op(OP_MUL, 16'h1234, 16'h0100);
    tick();
    n_tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_accept: got busy %b valid %b exp 1/0", busy, out_valid); end
    // Operand changes and a presented op while busy must be ignored.
    @(negedge clk); set_op(OP_ADD, 16'hAAAA, 16'h5555);
    busy_cnt = 1; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mul_timeout: got no out_valid exp pulse"); end
    n_tests++; if (busy_cnt != 16) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d exp 16", busy_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_drop: got %b exp 0", busy); end
    n_tests++; if (result !== 16'h3400 || result_hi !== 16'h0012) begin n_fail++; $display("FAIL mul_prod: got %h_%h exp 0012_3400", result_hi, result); end
    n_tests++; if (ccr !== 3'b100 || mem_addr !== 16'h0100) begin n_fail++; $display("FAIL mul_ccr_addr: got %b/%h exp 100/0100", ccr, mem_addr); end
    // Next op accepted at the edge right after busy falls.
    @(negedge clk); set_op(OP_ADD, 16'h0001, 16'h0001);
    tick();
    n_tests++; if (out_valid !== 1'b1 || result !== 16'h0002 || result_hi !== 16'h0000) begin n_fail++; $display("FAIL post_mul_add: got %b/%h/%h exp 1/0002/0000", out_valid, result, result_hi); end
    n_tests++; if (ccr !== 3'b000) begin n_fail++; $display("FAIL post_mul_ccr: got %b exp 000", ccr); end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_mul_flags();
    bit seen;
    int busy_cnt;
    run_mul(16'h0100, 16'h0100, seen, busy_cnt);
    n_tests++; if (!seen || result !== 16'h0000 || result_hi !== 16'h0001 || ccr !== 3'b000) begin n_fail++; $display("FAIL mul_hi_only: got %b %h_%h/%b exp 1 0001_0000/000", seen, result_hi, result, ccr); end
    run_mul(16'h0000, 16'h1234, seen, busy_cnt);
    n_tests++; if (!seen || {result_hi, result} !== 32'h0 || ccr !== 3'b001) begin n_fail++; $display("FAIL mul_zero: got %b %h_%h/%b exp 1 0000_0000/001", seen, result_hi, result, ccr); end
    run_mul(16'hFFFF, 16'hFFFF, seen, busy_cnt);
    n_tests++; if (!seen || result !== 16'h0001 || result_hi !== 16'hFFFE || ccr !== 3'b010) begin n_fail++; $display("FAIL mul_max: got %b %h_%h/%b exp 1 fffe_0001/010", seen, result_hi, result, ccr); end
  endtask

  task automatic test_flush();
    int vcnt;
    @(negedge clk); set_op(OP_MUL, 16'h0003, 16'h0004);
    tick();                     // acceptance edge
    repeat (4) tick();
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    tick();                     // cycle 5: flush edge
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got busy %b valid %b exp 0/0", busy, out_valid); end
    n_tests++; if (ccr !== 3'b010) begin n_fail++; $display("FAIL flush_ccr: got %b exp 010", ccr); end
    @(negedge clk); flush = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (out_valid) vcnt++; end
    n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL flush_no_pulse: got %0d pulses exp 0", vcnt); end
    // Flush together with in_valid in IDLE drops the op.
    @(negedge clk); set_op(OP_ADD, 16'h0002, 16'h0003); flush = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || result !== 16'h0001 || result_hi !== 16'hFFFE) begin n_fail++; $display("FAIL flush_idle: got %b/%h/%h exp 0/0001/fffe", out_valid, result, result_hi); end
    @(negedge clk); flush = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || result !== 16'h0005 || result_hi !== 16'h0000 || ccr !== 3'b000) begin n_fail++; $display("FAIL flush_then_add: got %b/%h/%h/%b exp 1/0005/0000/000", out_valid, result, result_hi, ccr); end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_op(OP_ADD, 16'h0001, 16'h0002);
    tick();
    n_tests++; if (out_valid !== 1'b1 || result !== 16'h0003) begin n_fail++; $display("FAIL b2b_add: got %b/%h exp 1/0003", out_valid, result); end
    @(negedge clk); set_op(OP_SUB, 16'h0003, 16'h0005);
    tick();
    n_tests++; if (out_valid !== 1'b1 || result !== 16'hFFFE || ccr !== 3'b110) begin n_fail++; $display("FAIL b2b_sub: got %b/%h/%b exp 1/fffe/110", out_valid, result, ccr); end
    @(negedge clk); in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    int vcnt;
    @(negedge clk); set_op(OP_MUL, 16'h1234, 16'h0100);
    tick();
    repeat (7) tick();
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_ctl: got busy %b valid %b exp 0/0", busy, out_valid); end
    n_tests++; if ({result, result_hi, mem_addr} !== 48'h0 || ccr !== 3'b000) begin n_fail++; $display("FAIL rstmul_data: got %h/%h/%h/%b exp 0", result, result_hi, mem_addr, ccr); end
    @(negedge clk); rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (out_valid || busy) vcnt++; end
    n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL rstmul_no_pulse: got %0d active cycles exp 0", vcnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fwd_sub();
    test_shift();
    test_flags();
    test_inc_dec();
    test_mul();
    test_mul_flags();
    test_flush();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
